// File: rtl/gcd_pkg.sv
// Shared types for the GCD datapath: operand-reader FSM states and the operand word.
package gcd_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    EMPTY,
    HALF,
    FULL
  } state_t;

  typedef logic [DATA_WIDTH_DEF-1:0] word_t;

  // Number of operand words currently captured for a given state.
  function automatic logic [1:0] held_of(input state_t s);
    unique case (s)
      EMPTY:   held_of = 2'd0;
      HALF:    held_of = 2'd1;
      FULL:    held_of = 2'd2;
      default: held_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/gcd_operand_reader.sv
// Pops words from the operand FIFO (registered read port), pairs them into (A, B)
// and offers the pair to the GCD core on a valid/ready handshake.
module gcd_operand_reader
  import gcd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  fifo_empty_i,
  output logic                  fifo_rd_en_o,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  input  logic                  flush_i,
  output logic                  op_valid_o,
  input  logic                  op_ready_i,
  output logic [DATA_WIDTH-1:0] op_a_o,
  output logic [DATA_WIDTH-1:0] op_b_o,
  output logic [CNT_WIDTH-1:0]  pair_cnt_o
);

  state_t                state_q, state_d;
  logic                  inflight_q;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= EMPTY;
      inflight_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= fifo_rd_en_o;
      a_q        <= a_d;
      b_q        <= b_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    // Only request a word when a slot is free for it once it lands.
    fifo_rd_en_o = !fifo_empty_i && !flush_i &&
                   ((held_of(state_q) + {1'b0, inflight_q}) < 2'd2);
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;

    // Flush wins over both capture and handshake; any arriving word is dropped.
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (inflight_q) begin
            a_d     = fifo_data_i;
            state_d = HALF;
          end
        end
        HALF: begin
          if (inflight_q) begin
            b_d     = fifo_data_i;
            state_d = FULL;
          end
        end
        FULL: begin
          if (op_ready_i) begin
            state_d = EMPTY;
            cnt_d   = cnt_q + 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  assign op_valid_o = (state_q == FULL);
  assign op_a_o     = a_q;
  assign op_b_o     = b_q;
  assign pair_cnt_o = cnt_q;

endmodule
